regbank_arbiter: RTL and testbench

Two-port round-robin arbiter and sequencer for the 16 x 16-bit register bank. Accepts read and write requests from two requesters (ALU writeback/operand fetch on port 0, load/debug unit on port 1) over valid/ready handshakes. Issues at most one bank operation per cycle and returns read data with fixed latency. Sits between the requesters and the bank's single address/data/WEN interface.

---
 rtl/regbank_pkg.sv | 37 +++
 rtl/rr_arbiter2.sv | 41 ++++
 rtl/regbank_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_regbank_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regbank_pkg.sv
// Shared types and constants for the 16 x 16-bit register bank and its arbiter.
//
// Contents:
//   DW, AW, NREG     data width, address width, register count
//   opKind_e         request kind (read pair / write)
//   rspTag_t         in-flight read tag {valid, port, zeroA, zeroB}
//   TagIdle          empty tag, used for reset and bubbles
//   isR0()           true when an address selects register 0
//
// Optional build macro: REGBANK_ARB_R0_ZERO_EN (used by regbank_arbiter) makes
// register 0 read as zero and suppresses bank writes to it.
package regbank_pkg;

  localparam int unsigned DW   = 16;
  localparam int unsigned AW   = 4;
  localparam int unsigned NREG = 16;

  typedef enum logic {
    OpRead  = 1'b0,
    OpWrite = 1'b1
  } opKind_e;

  // zeroA/zeroB mark operands whose response must be forced to zero.
  typedef struct packed {
    logic valid;
    logic port;
    logic zeroA;
    logic zeroB;
  } rspTag_t;

  localparam rspTag_t TagIdle = '{valid: 1'b0, port: 1'b0, zeroA: 1'b0, zeroB: 1'b0};

  function automatic logic isR0(input logic [AW-1:0] addr);
    return addr == '0;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter.
//
// Ports:
//   CLK   in   clock, rising edge
//   RST   in   synchronous active-high reset; forces gnt to 0
//   req   in   [1:0] request vector, bit n = requester n
//   gnt   out  [1:0] one-hot grant (combinational), 0 when nothing requested
//
// With both requesting, the requester not granted last wins. lastGrant only
// moves when a grant is issued; its reset value of 1 gives requester 0 the
// first tie.
module rr_arbiter2 (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic lastGrant;

  always_comb begin
    gnt = 2'b00;
    if (!RST) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = lastGrant ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      lastGrant <= 1'b1;
    end else if (|gnt) begin
      lastGrant <= gnt[1];
    end
  end

endmodule

// File: rtl/regbank_arbiter.sv
// Two-port round-robin arbiter and sequencer in front of the 16 x 16-bit
// register bank. Accepts one read-pair or write request per cycle over a
// valid/ready handshake, drives the bank from registers, and returns read
// data two cycles after acceptance.
//
// Ports:
//   CLK, RST                         clock; synchronous active-high reset
//   Pn_VALID / Pn_READY              request handshake (n = 0, 1)
//   Pn_WRITE                         1 = write, 0 = read pair
//   Pn_ADDR_A, Pn_ADDR_B             read addresses
//   Pn_WADDR, Pn_WDATA               write address / data
//   Pn_RSP_VALID                     one-cycle read-data pulse
//   Pn_RSP_A, Pn_RSP_B               read data (pass-through from bank)
//   BANK_ADDR_A/B, BANK_WADDR        registered bank addresses
//   BANK_DATA, BANK_WEN              registered bank write data / enable
//   BANK_RA, BANK_RB                 bank registered read outputs
//
// Build macro REGBANK_ARB_R0_ZERO_EN: register 0 reads as zero; writes to it
// are accepted but never raise BANK_WEN.
//
// Pipeline: accept (edge N) -> bank drive regs (cycle N+1, bank samples at
// edge N+1) -> BANK_RA/RB valid and Pn_RSP_VALID high in the following cycle.
// A read accepted right after a write to the same register sees the new
// value because the bank writes one edge before it samples the read.
module regbank_arbiter
  import regbank_pkg::*;
(
  input  logic          CLK,
  input  logic          RST,

  input  logic          P0_VALID,
  output logic          P0_READY,
  input  logic          P0_WRITE,
  input  logic [AW-1:0] P0_ADDR_A,
  input  logic [AW-1:0] P0_ADDR_B,
  input  logic [AW-1:0] P0_WADDR,
  input  logic [DW-1:0] P0_WDATA,
  output logic          P0_RSP_VALID,
  output logic [DW-1:0] P0_RSP_A,
  output logic [DW-1:0] P0_RSP_B,

  input  logic          P1_VALID,
  output logic          P1_READY,
  input  logic          P1_WRITE,
  input  logic [AW-1:0] P1_ADDR_A,
  input  logic [AW-1:0] P1_ADDR_B,
  input  logic [AW-1:0] P1_WADDR,
  input  logic [DW-1:0] P1_WDATA,
  output logic          P1_RSP_VALID,
  output logic [DW-1:0] P1_RSP_A,
  output logic [DW-1:0] P1_RSP_B,

  output logic [AW-1:0] BANK_ADDR_A,
  output logic [AW-1:0] BANK_ADDR_B,
  output logic [AW-1:0] BANK_WADDR,
  output logic [DW-1:0] BANK_DATA,
  output logic          BANK_WEN,
  input  logic [DW-1:0] BANK_RA,
  input  logic [DW-1:0] BANK_RB
);

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic [1:0] gnt;
  logic       accept;

  rr_arbiter2 u_rr_arbiter2 (
    .CLK (CLK),
    .RST (RST),
    .req ({P1_VALID, P0_VALID}),
    .gnt (gnt)
  );

  assign P0_READY = P0_VALID & gnt[0];
  assign P1_READY = P1_VALID & gnt[1];
  assign accept   = |gnt;

  // ---------------------------------------------------------------------------
  // Payload select for the granted port
  // ---------------------------------------------------------------------------
  opKind_e       selOp;
  logic          selPort;
  logic [AW-1:0] selAddrA;
  logic [AW-1:0] selAddrB;
  logic [AW-1:0] selWaddr;
  logic [DW-1:0] selWdata;

  always_comb begin
    selPort = gnt[1];
    if (gnt[1]) begin
      selOp    = P1_WRITE ? OpWrite : OpRead;
      selAddrA = P1_ADDR_A;
      selAddrB = P1_ADDR_B;
      selWaddr = P1_WADDR;
      selWdata = P1_WDATA;
    end else begin
      selOp    = P0_WRITE ? OpWrite : OpRead;
      selAddrA = P0_ADDR_A;
      selAddrB = P0_ADDR_B;
      selWaddr = P0_WADDR;
      selWdata = P0_WDATA;
    end
  end

  // Register-0 handling: zero flags ride with the read tag, and writes to R0
  // are swallowed without touching the bank.
  logic selZeroA;
  logic selZeroB;
  logic selWriteBlocked;

`ifdef REGBANK_ARB_R0_ZERO_EN
  assign selZeroA        = isR0(selAddrA);
  assign selZeroB        = isR0(selAddrB);
  assign selWriteBlocked = isR0(selWaddr);
`else
  assign selZeroA        = 1'b0;
  assign selZeroB        = 1'b0;
  assign selWriteBlocked = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Issue stage and response tag shift
  // ---------------------------------------------------------------------------
  logic [AW-1:0] bankAddrAQ;
  logic [AW-1:0] bankAddrBQ;
  logic [AW-1:0] bankWaddrQ;
  logic [DW-1:0] bankDataQ;
  logic          bankWenQ;
  rspTag_t       tagS1Q;   // read issued to bank this cycle
  rspTag_t       tagS2Q;   // bank read data valid this cycle

  always_ff @(posedge CLK) begin
    if (RST) begin
      bankAddrAQ <= '0;
      bankAddrBQ <= '0;
      bankWaddrQ <= '0;
      bankDataQ  <= '0;
      bankWenQ   <= 1'b0;
      tagS1Q     <= TagIdle;
      tagS2Q     <= TagIdle;
    end else begin
      bankWenQ <= 1'b0;
      tagS1Q   <= TagIdle;
      tagS2Q   <= tagS1Q;
      if (accept) begin
        if (selOp == OpWrite) begin
          bankWaddrQ <= selWaddr;
          bankDataQ  <= selWdata;
          bankWenQ   <= ~selWriteBlocked;
        end else begin
          // Read addresses only move on reads so idle/write slots hold them.
          bankAddrAQ <= selAddrA;
          bankAddrBQ <= selAddrB;
          tagS1Q     <= '{valid: 1'b1, port: selPort, zeroA: selZeroA, zeroB: selZeroB};
        end
      end
    end
  end

  assign BANK_ADDR_A = bankAddrAQ;
  assign BANK_ADDR_B = bankAddrBQ;
  assign BANK_WADDR  = bankWaddrQ;
  assign BANK_DATA   = bankDataQ;
  assign BANK_WEN    = bankWenQ;

  // ---------------------------------------------------------------------------
  // Response outputs
  // ---------------------------------------------------------------------------
  logic [DW-1:0] rspA;
  logic [DW-1:0] rspB;

  assign rspA = tagS2Q.zeroA ? '0 : BANK_RA;
  assign rspB = tagS2Q.zeroB ? '0 : BANK_RB;

  assign P0_RSP_VALID = tagS2Q.valid & ~tagS2Q.port;
  assign P1_RSP_VALID = tagS2Q.valid &  tagS2Q.port;
  assign P0_RSP_A     = rspA;
  assign P0_RSP_B     = rspB;
  assign P1_RSP_A     = rspA;
  assign P1_RSP_B     = rspB;

endmodule

// File: tb/tb_regbank_arbiter.sv
// Scoreboard bench for regbank_arbiter with a behavioural 16 x 16 register
// bank attached (synchronous write, registered reads, zeroed by RST).
// Drivers push expected read data tagged with the cycle it must appear;
// a monitor pops and compares whenever a port shows RSP_VALID.
module tb_regbank_arbiter;
  import regbank_pkg::*;

`ifdef REGBANK_ARB_R0_ZERO_EN
  localparam bit R0Zero = 1'b1;
`else
  localparam bit R0Zero = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic          pValid [2];
  logic          pWrite [2];
  logic [AW-1:0] pAddrA [2];
  logic [AW-1:0] pAddrB [2];
  logic [AW-1:0] pWaddr [2];
  logic [DW-1:0] pWdata [2];
  logic [1:0]    pReady;
  logic          p0RspValid, p1RspValid;
  logic [DW-1:0] p0RspA, p0RspB, p1RspA, p1RspB;
  logic [AW-1:0] bankAddrA, bankAddrB, bankWaddr;
  logic [DW-1:0] bankData, bankRa, bankRb;
  logic          bankWen;

  regbank_arbiter dut (
    .CLK          (CLK),
    .RST          (RST),
    .P0_VALID     (pValid[0]),
    .P0_READY     (pReady[0]),
    .P0_WRITE     (pWrite[0]),
    .P0_ADDR_A    (pAddrA[0]),
    .P0_ADDR_B    (pAddrB[0]),
    .P0_WADDR     (pWaddr[0]),
    .P0_WDATA     (pWdata[0]),
    .P0_RSP_VALID (p0RspValid),
    .P0_RSP_A     (p0RspA),
    .P0_RSP_B     (p0RspB),
    .P1_VALID     (pValid[1]),
    .P1_READY     (pReady[1]),
    .P1_WRITE     (pWrite[1]),
    .P1_ADDR_A    (pAddrA[1]),
    .P1_ADDR_B    (pAddrB[1]),
    .P1_WADDR     (pWaddr[1]),
    .P1_WDATA     (pWdata[1]),
    .P1_RSP_VALID (p1RspValid),
    .P1_RSP_A     (p1RspA),
    .P1_RSP_B     (p1RspB),
    .BANK_ADDR_A  (bankAddrA),
    .BANK_ADDR_B  (bankAddrB),
    .BANK_WADDR   (bankWaddr),
    .BANK_DATA    (bankData),
    .BANK_WEN     (bankWen),
    .BANK_RA      (bankRa),
    .BANK_RB      (bankRb)
  );

  // Register bank model
  logic [DW-1:0] mem [NREG];
  always @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
      bankRa <= '0;
      bankRb <= '0;
    end else begin
      if (bankWen) mem[bankWaddr] <= bankData;
      bankRa <= mem[bankAddrA];
      bankRb <= mem[bankAddrB];
    end
  end

  // Scoreboard
  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    int            cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   grantLog[$];
  int   checks  = 0;
  int   errors  = 0;
  int   rspSeen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples 2 time units after each falling edge.
  exp_t e0, e1;
  always @(negedge CLK) begin
    #2;
    chk("ready exclusive", {31'd0, &pReady}, 32'd0);
    if (p0RspValid === 1'b1) begin
      rspSeen++;
      if (q0.size() == 0) begin
        chk("p0 unexpected rsp", 32'd1, 32'd0);
      end else begin
        e0 = q0.pop_front();
        chk("p0 rsp A", {16'd0, p0RspA}, {16'd0, e0.a});
        chk("p0 rsp B", {16'd0, p0RspB}, {16'd0, e0.b});
        chk("p0 rsp cycle", cyc, e0.cyc);
      end
    end
    if (p1RspValid === 1'b1) begin
      rspSeen++;
      if (q1.size() == 0) begin
        chk("p1 unexpected rsp", 32'd1, 32'd0);
      end else begin
        e1 = q1.pop_front();
        chk("p1 rsp A", {16'd0, p1RspA}, {16'd0, e1.a});
        chk("p1 rsp B", {16'd0, p1RspB}, {16'd0, e1.b});
        chk("p1 rsp cycle", cyc, e1.cyc);
      end
    end
  end

  // Issue one request on port p; call and return at a falling edge.
  // acc = cycle in which READY was high, waited = cycles spent waiting.
  task automatic req(input int p, input logic wr, input logic [AW-1:0] aa, input logic [AW-1:0] ab,
                     input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                     input logic [DW-1:0] ea, input logic [DW-1:0] eb, input bit noRsp,
                     output int acc, output int waited);
    exp_t e;
    int   t;
    pWrite[p] = wr;
    pAddrA[p] = aa;
    pAddrB[p] = ab;
    pWaddr[p] = wa;
    pWdata[p] = wd;
    pValid[p] = 1'b1;
    t = 0;
    #2;
    while (!pReady[p] && t < 20) begin
      @(negedge CLK);
      #2;
      t++;
    end
    acc    = cyc;
    waited = t;
    if (!pReady[p]) begin
      chk($sformatf("p%0d accept timeout", p), 32'd0, 32'd1);
    end else begin
      grantLog.push_back(p);
      if (!wr && !noRsp) begin
        e.a   = ea;
        e.b   = eb;
        e.cyc = acc + 2;
        if (p == 0) q0.push_back(e);
        else        q1.push_back(e);
      end
    end
    @(negedge CLK);
    pValid[p] = 1'b0;
  endtask

  logic [DW-1:0] r0Val;
  int acc0, acc1, w0, w1, rsBefore;

  initial begin
    RST = 1'b1;
    for (int p = 0; p < 2; p++) begin
      pValid[p] = 1'b1;   // held high in reset: READY must stay low
      pWrite[p] = 1'b0;
      pAddrA[p] = '0;
      pAddrB[p] = '0;
      pWaddr[p] = '0;
      pWdata[p] = '0;
    end

    // Reset state
    repeat (2) @(negedge CLK);
    #2;
    chk("reset p0 ready", {31'd0, pReady[0]}, 32'd0);
    chk("reset p1 ready", {31'd0, pReady[1]}, 32'd0);
    chk("reset p0 rsp valid", {31'd0, p0RspValid}, 32'd0);
    chk("reset p1 rsp valid", {31'd0, p1RspValid}, 32'd0);
    chk("reset bank wen", {31'd0, bankWen}, 32'd0);
    chk("reset bank addrs", {20'd0, bankAddrA, bankAddrB, bankWaddr}, 32'd0);
    chk("reset bank data", {16'd0, bankData}, 32'd0);
    @(negedge CLK);
    pValid[0] = 1'b0;
    pValid[1] = 1'b0;
    RST = 1'b0;
    @(negedge CLK);

    // Writes from P0, then read pairs
    r0Val = R0Zero ? 16'h0000 : 16'h0001;
    req(0, 1'b1, 4'd0, 4'd0, 4'd0, 16'h0001, '0, '0, 1'b0, acc0, w0);
    req(0, 1'b1, 4'd0, 4'd0, 4'd5, 16'h0005, '0, '0, 1'b0, acc0, w0);
    #2;
    chk("write issue wen", {31'd0, bankWen}, 32'd1);
    chk("write issue waddr", {28'd0, bankWaddr}, 32'd5);
    chk("write issue data", {16'd0, bankData}, 32'h0005);
    @(negedge CLK);
    req(0, 1'b1, 4'd0, 4'd0, 4'd11, 16'h000B, '0, '0, 1'b0, acc0, w0);
    req(0, 1'b1, 4'd0, 4'd0, 4'd15, 16'h000F, '0, '0, 1'b0, acc0, w0);
    req(0, 1'b0, 4'd0, 4'd5, 4'd0, '0, r0Val, 16'h0005, 1'b0, acc0, w0);
    req(0, 1'b0, 4'd11, 4'd15, 4'd0, '0, 16'h000B, 16'h000F, 1'b0, acc0, w0);

    // Write on P0 then read of the same register on P1 the next cycle
    req(0, 1'b1, 4'd0, 4'd0, 4'd3, 16'hBEEF, '0, '0, 1'b0, acc0, w0);
    req(1, 1'b0, 4'd3, 4'd3, 4'd0, '0, 16'hBEEF, 16'hBEEF, 1'b0, acc1, w1);
    chk("p1 read accepted next cycle", acc1, acc0 + 1);

    // Both ports streaming reads: last grant was P1, so P0 leads.
    grantLog.delete();
    fork
      begin
        req(0, 1'b0, 4'd0, 4'd5, 4'd0, '0, r0Val, 16'h0005, 1'b0, acc0, w0);
        chk("p0 wait 1st", w0, 0);
        req(0, 1'b0, 4'd11, 4'd15, 4'd0, '0, 16'h000B, 16'h000F, 1'b0, acc0, w0);
        chk("p0 wait 2nd", w0, 1);
        req(0, 1'b0, 4'd3, 4'd0, 4'd0, '0, 16'hBEEF, r0Val, 1'b0, acc0, w0);
        chk("p0 wait 3rd", w0, 1);
        req(0, 1'b0, 4'd5, 4'd11, 4'd0, '0, 16'h0005, 16'h000B, 1'b0, acc0, w0);
        chk("p0 wait 4th", w0, 1);
      end
      begin
        req(1, 1'b0, 4'd15, 4'd3, 4'd0, '0, 16'h000F, 16'hBEEF, 1'b0, acc1, w1);
        chk("p1 wait 1st", w1, 1);
        req(1, 1'b0, 4'd0, 4'd11, 4'd0, '0, r0Val, 16'h000B, 1'b0, acc1, w1);
        chk("p1 wait 2nd", w1, 1);
        req(1, 1'b0, 4'd5, 4'd5, 4'd0, '0, 16'h0005, 16'h0005, 1'b0, acc1, w1);
        chk("p1 wait 3rd", w1, 1);
        req(1, 1'b0, 4'd3, 4'd15, 4'd0, '0, 16'hBEEF, 16'h000F, 1'b0, acc1, w1);
        chk("p1 wait 4th", w1, 1);
      end
    join
    chk("grant log length", grantLog.size(), 8);
    for (int i = 0; i < 8 && i < grantLog.size(); i++) begin
      chk($sformatf("grant order %0d", i), grantLog[i], i % 2);
    end
    repeat (4) @(negedge CLK);

    // Reset one cycle after a read is accepted: no response may appear.
    rsBefore = rspSeen;
    req(0, 1'b0, 4'd3, 4'd5, 4'd0, '0, '0, '0, 1'b1, acc0, w0);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    #2;
    chk("post-reset bank addrs", {20'd0, bankAddrA, bankAddrB, bankWaddr}, 32'd0);
    @(negedge CLK);
    repeat (3) @(negedge CLK);
    chk("no rsp after reset", rspSeen, rsBefore);
    req(0, 1'b0, 4'd2, 4'd3, 4'd0, '0, 16'h0000, 16'h0000, 1'b0, acc0, w0);

    // Write to R0 then read it back
    req(0, 1'b1, 4'd0, 4'd0, 4'd0, 16'h1234, '0, '0, 1'b0, acc0, w0);
    #2;
    chk("r0 write wen", {31'd0, bankWen}, R0Zero ? 32'd0 : 32'd1);
    @(negedge CLK);
    req(0, 1'b0, 4'd0, 4'd1, 4'd0, '0, R0Zero ? 16'h0000 : 16'h1234, 16'h0000, 1'b0, acc0, w0);
    repeat (3) @(negedge CLK);

    // Idle: no writes, no responses
    rsBefore = rspSeen;
    for (int i = 0; i < 10; i++) begin
      #2;
      chk("idle wen", {31'd0, bankWen}, 32'd0);
      @(negedge CLK);
    end
    chk("idle no rsp", rspSeen, rsBefore);
    chk("p0 queue drained", q0.size(), 0);
    chk("p1 queue drained", q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop if the sequence ever stalls.
  initial begin
    #20000;
    $display("FAIL global timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
